// File: rtl/chip8_fetch_sequencer.sv
// CHIP-8 instruction sequencer: owns PC and call stack, fetches opcodes, runs control flow.
// Optional STACK_TRAP_EN: stack overflow/underflow halts the core with a sticky fault.
module chip8_fetch_sequencer #(
  parameter int          STACK_DEPTH = 16,
  parameter logic [11:0] RESET_PC    = 12'h200
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        run,
  output logic        mem_req,
  output logic [11:0] mem_addr,
  input  logic        mem_ack,
  input  logic [7:0]  mem_rdata,
  output logic [15:0] opcode,
  output logic [11:0] pc,
  input  logic [3:0]  op_main,
  input  logic [3:0]  op_sub,
  input  logic [11:0] nnn,
  input  logic [7:0]  nn,
  input  logic [7:0]  vx,
  input  logic [7:0]  vy,
  input  logic [7:0]  v0,
  output logic        exec_start,
  input  logic        exec_done,
  output logic        fault
);

  localparam int IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
  localparam int SP_W  = IDX_W + 1;

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_FETCH_HI  = 3'd1;
  localparam logic [2:0] S_FETCH_LO  = 3'd2;
  localparam logic [2:0] S_DECODE    = 3'd3;
  localparam logic [2:0] S_EXEC_WAIT = 3'd4;
  localparam logic [2:0] S_HALT      = 3'd5;

  localparam logic [3:0] OP_SYS   = 4'h0;
  localparam logic [3:0] OP_JP    = 4'h1;
  localparam logic [3:0] OP_CALL  = 4'h2;
  localparam logic [3:0] OP_SE    = 4'h3;
  localparam logic [3:0] OP_SNE   = 4'h4;
  localparam logic [3:0] OP_SEXY  = 4'h5;
  localparam logic [3:0] OP_SNEXY = 4'h9;
  localparam logic [3:0] OP_JPV0  = 4'hB;
  localparam logic [3:0] SUB_RET  = 4'hE;

  logic [2:0]       state;
  logic [2:0]       state_nx;
  logic [11:0]      pc_r;
  logic [15:0]      opcode_r;
  logic             exec_start_r;
  logic [SP_W-1:0]  sp;
  logic [SP_W-1:0]  sp_push;
  logic [SP_W-1:0]  sp_pop;
  logic [IDX_W-1:0] sp_idx;
  logic [IDX_W-1:0] sp_idx_dec;
  logic [11:0]      stack [STACK_DEPTH];

  logic             is_push;
  logic             is_pop;
  logic             is_flow;
  logic             take_skip;
  logic             stack_err;
  logic [11:0]      pc_target;

  function automatic logic [11:0] pc_add(input logic [11:0] base, input logic [11:0] ofs);
    return base + ofs;
  endfunction

  assign sp_idx     = sp[IDX_W-1:0];
  assign sp_idx_dec = sp_idx - IDX_W'(1);

`ifdef STACK_TRAP_EN
  logic fault_r;

  assign sp_push   = sp + SP_W'(1);
  assign sp_pop    = sp - SP_W'(1);
  assign stack_err = (is_push && (sp == SP_W'(STACK_DEPTH))) || (is_pop && (sp == '0));
  assign fault     = fault_r;
`else
  // Without the trap the pointer simply wraps, so the oldest entry gets recycled.
  assign sp_push   = {1'b0, sp_idx + IDX_W'(1)};
  assign sp_pop    = {1'b0, sp_idx_dec};
  assign stack_err = 1'b0;
  assign fault     = 1'b0;
`endif

  assign mem_req    = (state == S_FETCH_HI) || (state == S_FETCH_LO);
  assign mem_addr   = (state == S_FETCH_LO) ? pc_add(pc_r, 12'd1) : pc_r;
  assign opcode     = opcode_r;
  assign pc         = pc_r;
  assign exec_start = exec_start_r;

  always_comb begin
    is_push   = (op_main == OP_CALL);
    is_pop    = (op_main == OP_SYS) && (op_sub == SUB_RET);
    take_skip = 1'b0;
    case (op_main)
      OP_SE:    take_skip = (vx == nn);
      OP_SNE:   take_skip = (vx != nn);
      OP_SEXY:  take_skip = (vx == vy);
      OP_SNEXY: take_skip = (vx != vy);
      default:  take_skip = 1'b0;
    endcase
    is_flow = is_push || is_pop ||
              (op_main inside {OP_JP, OP_JPV0, OP_SE, OP_SNE, OP_SEXY, OP_SNEXY});
  end

  // pc already points past the current instruction here, so it is the return address.
  always_comb begin
    pc_target = pc_r;
    if (is_pop) begin
      pc_target = stack[sp_idx_dec];
    end else begin
      case (op_main)
        OP_JP, OP_CALL: pc_target = nnn;
        OP_JPV0:        pc_target = pc_add(nnn, {4'h0, v0});
        default:        pc_target = take_skip ? pc_add(pc_r, 12'd2) : pc_r;
      endcase
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:      if (run) state_nx = S_FETCH_HI;
      S_FETCH_HI:  if (mem_ack) state_nx = S_FETCH_LO;
      S_FETCH_LO:  if (mem_ack) state_nx = S_DECODE;
      S_DECODE: begin
        if (stack_err)    state_nx = S_HALT;
        else if (is_flow) state_nx = run ? S_FETCH_HI : S_IDLE;
        else              state_nx = S_EXEC_WAIT;
      end
      S_EXEC_WAIT: if (exec_done) state_nx = run ? S_FETCH_HI : S_IDLE;
      S_HALT:      state_nx = S_HALT;
      default:     state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      pc_r         <= RESET_PC;
      opcode_r     <= 16'h0000;
      sp           <= '0;
      exec_start_r <= 1'b0;
    end else begin
      state        <= state_nx;
      exec_start_r <= 1'b0;
      case (state)
        S_FETCH_HI: begin
          if (mem_ack) opcode_r[15:8] <= mem_rdata;
        end
        S_FETCH_LO: begin
          if (mem_ack) begin
            opcode_r[7:0] <= mem_rdata;
            pc_r          <= pc_add(pc_r, 12'd2);
          end
        end
        S_DECODE: begin
          if (!stack_err) begin
            pc_r <= pc_target;
            if (is_push) sp <= sp_push;
            if (is_pop)  sp <= sp_pop;
          end
          if (!is_flow) exec_start_r <= 1'b1;
        end
        default: ;
      endcase
    end
  end

`ifdef STACK_TRAP_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fault_r <= 1'b0;
    end else if ((state == S_DECODE) && stack_err) begin
      fault_r <= 1'b1;
    end
  end
`endif

  // Stack contents are plain storage and deliberately carry no reset.
  always_ff @(posedge clk) begin
    if ((state == S_DECODE) && is_push && !stack_err) begin
      stack[sp_idx] <= pc_r;
    end
  end

endmodule

// File: tb/tb_chip8_fetch_sequencer.sv
// Bench for chip8_fetch_sequencer: instruction-level model of PC/stack plus memory and execute responders.
module tb_chip8_fetch_sequencer;

  localparam int D = 16;
`ifdef STACK_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  localparam int PH_IDLE = 0, PH_FETCH = 1, PH_DEC = 2, PH_EXW = 3, PH_HALT = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        run = 1'b0;
  logic        mem_ack = 1'b0;
  logic [7:0]  mem_rdata = 8'h00;
  logic        exec_done = 1'b0;
  logic        mem_req;
  logic [11:0] mem_addr;
  logic [15:0] opcode;
  logic [11:0] pc;
  logic        exec_start;
  logic        fault;
  logic [3:0]  op_main, op_sub;
  logic [11:0] nnn;
  logic [7:0]  nn, vx, vy, v0;

  logic [7:0]  mem  [4096];
  logic [7:0]  regs [16];

  // Stand-in decoder and register file
  assign op_main = opcode[15:12];
  assign op_sub  = opcode[3:0];
  assign nnn     = opcode[11:0];
  assign nn      = opcode[7:0];
  assign vx      = regs[opcode[11:8]];
  assign vy      = regs[opcode[7:4]];
  assign v0      = regs[0];

  chip8_fetch_sequencer #(.STACK_DEPTH(D), .RESET_PC(12'h200)) dut (
    .clk(clk), .rst_n(rst_n), .run(run),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .opcode(opcode), .pc(pc),
    .op_main(op_main), .op_sub(op_sub), .nnn(nnn), .nn(nn),
    .vx(vx), .vy(vy), .v0(v0),
    .exec_start(exec_start), .exec_done(exec_done), .fault(fault)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model state
  int ph = PH_IDLE, A = 'h200, bidx = 0, wcnt = 0, ew = 0, cyc = 0;
  int mem_wait = 0, exec_lat = 0, exec_starts = 0;
  bit spur = 1'b0;
  int mop = 0, nxt_a = 0, halt_pc = 0, msp = 0;
  bit m_exec = 1'b0, m_halt = 1'b0, m_fault = 1'b0;
  int mstk [D];
  int ack_addr [$];
  int ack_cyc  [$];
  int done_q   [$];

  // Architectural effect of the instruction at A, taken once both bytes are read.
  task automatic model_exec();
    int op, x, y;
    op     = {mem[A], mem[(A + 1) % 4096]};
    x      = (op >> 8) & 15;
    y      = (op >> 4) & 15;
    mop    = op;
    nxt_a  = (A + 2) % 4096;
    m_exec = 1'b0;
    m_halt = 1'b0;
    case (op >> 12)
      1:   nxt_a = op & 'hFFF;
      'hB: nxt_a = ((op & 'hFFF) + regs[0]) % 4096;
      2: begin
        if (TRAP && msp == D) m_halt = 1'b1;
        else begin
          mstk[msp % D] = nxt_a;
          msp   = TRAP ? msp + 1 : (msp + 1) % D;
          nxt_a = op & 'hFFF;
        end
      end
      0: begin
        if ((op & 15) == 14) begin
          if (TRAP && msp == 0) m_halt = 1'b1;
          else begin
            msp   = TRAP ? msp - 1 : (msp + D - 1) % D;
            nxt_a = mstk[msp];
          end
        end else m_exec = 1'b1;
      end
      3: if (regs[x] == (op & 'hFF)) nxt_a = (nxt_a + 2) % 4096;
      4: if (regs[x] != (op & 'hFF)) nxt_a = (nxt_a + 2) % 4096;
      5: if (regs[x] == regs[y]) nxt_a = (nxt_a + 2) % 4096;
      9: if (regs[x] != regs[y]) nxt_a = (nxt_a + 2) % 4096;
      default: m_exec = 1'b1;
    endcase
  endtask

  // Compare process, also acting as memory and execute-unit responder
  initial begin
    for (int i = 0; i < D; i++) mstk[i] = 0;
    forever begin
      @(negedge clk);
      cyc++;
      mem_ack   = 1'b0;
      exec_done = 1'b0;
      if (rst_n && exec_start) exec_starts++;
      if (!rst_n) begin
        chk("rst_mem_req", mem_req, 0);
        chk("rst_pc", pc, 'h200);
        chk("rst_mem_addr", mem_addr, 'h200);
        chk("rst_opcode", opcode, 0);
        chk("rst_exec_start", exec_start, 0);
        chk("rst_fault", fault, 0);
        mem_ack = 1'b1;
        ph = PH_IDLE; A = 'h200; bidx = 0; wcnt = 0; msp = 0; m_fault = 1'b0;
      end else begin
        chk("fault", fault, m_fault);
        case (ph)
          PH_IDLE: begin
            chk("idle_mem_req", mem_req, 0);
            chk("idle_pc", pc, A);
            chk("idle_exec_start", exec_start, 0);
            if (spur) mem_ack = 1'b1;
            if (run) ph = PH_FETCH;
          end
          PH_FETCH: begin
            chk("fetch_mem_req", mem_req, 1);
            chk("fetch_mem_addr", mem_addr, (A + bidx) % 4096);
            chk("fetch_pc", pc, A);
            chk("fetch_exec_start", exec_start, 0);
            if (mem_req) begin
              if (wcnt >= mem_wait) begin
                mem_ack   = 1'b1;
                mem_rdata = mem[(A + bidx) % 4096];
                ack_addr.push_back((A + bidx) % 4096);
                ack_cyc.push_back(cyc);
                wcnt = 0;
                if (bidx == 0) bidx = 1;
                else begin
                  bidx = 0;
                  model_exec();
                  ph = PH_DEC;
                end
              end else begin
                wcnt++;
                mem_rdata = 8'($urandom);
              end
            end
          end
          PH_DEC: begin
            chk("dec_mem_req", mem_req, 0);
            chk("dec_exec_start", exec_start, 0);
            chk("dec_opcode", opcode, mop);
            chk("dec_pc", pc, (A + 2) % 4096);
            if (spur) begin exec_done = 1'b1; mem_ack = 1'b1; end
            if (m_halt) begin
              ph = PH_HALT; m_fault = 1'b1; halt_pc = (A + 2) % 4096;
            end else if (m_exec) begin
              ph = PH_EXW; ew = 0;
            end else begin
              A  = nxt_a;
              ph = run ? PH_FETCH : PH_IDLE;
            end
          end
          PH_EXW: begin
            chk("exw_mem_req", mem_req, 0);
            chk("exw_opcode", opcode, mop);
            chk("exw_pc", pc, (A + 2) % 4096);
            chk("exw_exec_start", exec_start, (ew == 0) ? 1 : 0);
            if (spur) mem_ack = 1'b1;
            if (ew == exec_lat) begin
              exec_done = 1'b1;
              done_q.push_back(cyc);
              A  = nxt_a;
              ph = run ? PH_FETCH : PH_IDLE;
            end else ew++;
          end
          default: begin
            chk("halt_mem_req", mem_req, 0);
            chk("halt_exec_start", exec_start, 0);
            chk("halt_pc", pc, halt_pc);
          end
        endcase
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic clr_mem();
    for (int i = 0; i < 4096; i++) mem[i] = 8'h00;
  endtask

  task automatic put(input int a, input int op);
    mem[a]     = 8'(op >> 8);
    mem[a + 1] = 8'(op);
  endtask

  task automatic start_test(input int wait_st, input int lat, input bit spurious);
    step(1);
    rst_n = 1'b0;
    mem_wait = wait_st; exec_lat = lat; spur = spurious;
    ack_addr.delete(); ack_cyc.delete(); done_q.delete();
    exec_starts = 0;
    run = 1'b1;
    step(2);
    rst_n = 1'b1;
  endtask

  task automatic wait_acks(input int n, input int budget);
    int b = budget;
    while (ack_addr.size() < n && b > 0) begin step(1); b--; end
    chk("ack_budget", int'(ack_addr.size() >= n), 1);
  endtask

  task automatic lit_addr(input string nm, input int idx, input int exp);
    int v;
    v = (idx < ack_addr.size()) ? ack_addr[idx] : -1;
    chk(nm, v, exp);
  endtask

  function automatic int cyc_at(input int idx);
    return (idx < ack_cyc.size()) ? ack_cyc[idx] : -1000;
  endfunction

  function automatic int done_at(input int idx);
    return (idx < done_q.size()) ? done_q[idx] : -2000;
  endfunction

  initial begin
    for (int i = 0; i < 16; i++) regs[i] = 8'h00;
    clr_mem();
    step(3);

    // Jump
    put('h200, 'h1248); put('h248, 'h1248);
    start_test(0, 0, 1'b0);
    wait_acks(6, 50);
    lit_addr("jp_a0", 0, 'h200);
    lit_addr("jp_a1", 1, 'h201);
    lit_addr("jp_a2", 2, 'h248);
    lit_addr("jp_a3", 3, 'h249);
    chk("jp_cycles", cyc_at(2) - cyc_at(1), 2);

    // Call/return, wait states, run dropped mid-fetch
    clr_mem();
    put('h200, 'h2300); put('h300, 'h00EE); put('h202, 'h1202);
    start_test(2, 0, 1'b0);
    wait_acks(1, 50);
    run = 1'b0;
    step(12);
    chk("idle_hold_req", mem_req, 0);
    chk("idle_hold_pc", pc, 'h300);
    run = 1'b1;
    wait_acks(6, 80);
    lit_addr("call_a2", 2, 'h300);
    lit_addr("ret_a4", 4, 'h202);

    // 3XNN taken / not taken
    clr_mem();
    regs[10] = 8'h55;
    put('h200, 'h3A55); put('h204, 'h1204);
    start_test(0, 0, 1'b0);
    wait_acks(3, 40);
    lit_addr("se_taken", 2, 'h204);
    regs[10] = 8'h54;
    put('h202, 'h1202);
    start_test(0, 0, 1'b0);
    wait_acks(3, 40);
    lit_addr("se_not_taken", 2, 'h202);

    // Register skips, BNNN and address wrap
    clr_mem();
    regs[0] = 8'h08; regs[1] = 8'h10; regs[2] = 8'h10; regs[3] = 8'h20;
    put('h200, 'h4110); put('h202, 'h5120); put('h206, 'h9130); put('h20A, 'hB300);
    put('h308, 'hBFFC); put('h004, 'h1FFE); put('hFFE, 'h3110); put('h002, 'h1002);
    start_test(1, 0, 1'b1);
    wait_acks(16, 200);
    lit_addr("sne_no_skip", 2, 'h202);
    lit_addr("sexy_skip", 4, 'h206);
    lit_addr("snexy_skip", 6, 'h20A);
    lit_addr("jpv0", 8, 'h308);
    lit_addr("jpv0_wrap", 10, 'h004);
    lit_addr("lo_wrap", 13, 'hFFF);
    lit_addr("skip_wrap", 14, 'h002);

    // Executed instructions with a slow and a fast execute unit
    clr_mem();
    put('h200, 'h8124); put('h202, 'h00E0); put('h204, 'h1204);
    start_test(0, 5, 1'b1);
    wait_acks(6, 100);
    chk("exec_pulses", exec_starts, 2);
    chk("exec_resume0", cyc_at(2) - done_at(0), 1);
    chk("exec_resume1", cyc_at(4) - done_at(1), 1);
    chk("exec_total", cyc_at(2) - cyc_at(0), 9);
    start_test(0, 1, 1'b0);
    wait_acks(6, 60);
    chk("exec_fast_pulses", exec_starts, 2);

    // 17 nested calls
    clr_mem();
    for (int k = 0; k < 17; k++) put('h200 + 16 * k, 'h2000 | ('h200 + 16 * (k + 1)));
    put('h310, 'h00EE); put('h302, 'h00EE); put('h2F2, 'h12F2);
    start_test(0, 0, 1'b0);
    step(150);
`ifdef STACK_TRAP_EN
    chk("ovf_fault", fault, 1);
    chk("ovf_pc", pc, 'h302);
`else
    chk("wrap_fault", fault, 0);
    chk("wrap_last", (ack_addr.size() > 0) ? (ack_addr[ack_addr.size() - 1] & 'hFFE) : -1, 'h2F2);
`endif

    // Return with an empty stack
    clr_mem();
    put('h200, 'h00EE);
    start_test(0, 0, 1'b0);
    step(20);
`ifdef STACK_TRAP_EN
    chk("udf_fault", fault, 1);
    chk("udf_pc", pc, 'h202);
`else
    chk("udf_fault", fault, 0);
    lit_addr("udf_oldest", 2, 'h2F2);
`endif

    // Asynchronous reset in the middle of the low-byte read
    clr_mem();
    put('h200, 'h1248); put('h248, 'h1248);
    start_test(3, 0, 1'b0);
    begin
      int b = 40;
      while (!(ph == PH_FETCH && bidx == 1) && b > 0) begin step(1); b--; end
    end
    chk("lo_req", mem_req, 1);
    chk("lo_addr", mem_addr, 'h201);
    rst_n = 1'b0;
    #1;
    chk("async_req", mem_req, 0);
    chk("async_pc", pc, 'h200);
    chk("async_addr", mem_addr, 'h200);
    ack_addr.delete(); ack_cyc.delete();
    step(3);
    rst_n = 1'b1;
    wait_acks(2, 40);
    lit_addr("restart_a0", 0, 'h200);
    lit_addr("restart_a1", 1, 'h201);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
